inst_queue: RTL and testbench

Dual-write, dual-read instruction queue between the fetch stage and the decode/issue stage. It accepts up to two fetched instructions per cycle (one 64-bit fetch word split into two PC-tagged slots), holds them in program order, and presents the two oldest entries to decode. Decode pops one or two entries per cycle according to its issue decision. Branch redirects and exceptions clear the queue through `flush`.

---
 rtl/inst_queue.sv | 115 +++++++++++
 tb/tb_inst_queue.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// Dual-write, dual-read instruction queue between fetch and decode.
// Keeps entries in program order and presents the two oldest to decode.
module inst_queue #(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stall,
  input  logic [31:0]                wr_inst1_i,
  input  logic [31:0]                wr_inst1_pc_i,
  input  logic                       wr_inst1_valid_i,
  input  logic [31:0]                wr_inst2_i,
  input  logic [31:0]                wr_inst2_pc_i,
  input  logic                       wr_inst2_valid_i,
  input  logic                       issue_i,
  input  logic                       issue_mode_i,
  output logic [31:0]                issue_inst1_o,
  output logic [31:0]                issue_inst1_pc_o,
  output logic                       issue_inst1_valid_o,
  output logic [31:0]                issue_inst2_o,
  output logic [31:0]                issue_inst2_pc_o,
  output logic                       issue_inst2_valid_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] count;
  logic          overflow_q;

  logic [CW-1:0] free;
  logic [1:0]    n_valid;
  logic [1:0]    want_pop;
  logic [1:0]    writes;
  logic [1:0]    pops;
  logic          drop;
  logic [31:0]   first_inst;
  logic [31:0]   first_pc;
  logic [AW-1:0] tail_p1;
  logic [AW-1:0] head_p1;

  // Free space is taken from the count before this cycle's pops, so a full
  // queue drops writes even while decode drains it.
  always_comb begin
    free       = CW'(DEPTH) - count;
    n_valid    = {1'b0, wr_inst1_valid_i} + {1'b0, wr_inst2_valid_i};
    want_pop   = issue_i ? (issue_mode_i ? 2'd2 : 2'd1) : 2'd0;
    writes     = (CW'(n_valid) <= free) ? n_valid : free[1:0];
    pops       = (CW'(want_pop) <= count) ? want_pop : count[1:0];
    drop       = CW'(n_valid) > free;
    first_inst = wr_inst1_valid_i ? wr_inst1_i    : wr_inst2_i;
    first_pc   = wr_inst1_valid_i ? wr_inst1_pc_i : wr_inst2_pc_i;
    tail_p1    = tail + 1'b1;
    head_p1    = head + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!flush && !stall) begin
      if (writes != 2'd0) begin
        inst_mem[tail] <= first_inst;
        pc_mem[tail]   <= first_pc;
      end
      if (writes == 2'd2) begin
        inst_mem[tail_p1] <= wr_inst2_i;
        pc_mem[tail_p1]   <= wr_inst2_pc_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else if (stall) begin
      overflow_q <= 1'b0;
    end else begin
      head       <= head + AW'(pops);
      tail       <= tail + AW'(writes);
      count      <= count + CW'(writes) - CW'(pops);
      overflow_q <= drop;
    end
  end

  // Data outputs are masked to zero whenever their valid flag is low.
  always_comb begin
    issue_inst1_valid_o = (count >= CW'(1));
    issue_inst2_valid_o = (count >= CW'(2));
    issue_inst1_o       = issue_inst1_valid_o ? inst_mem[head]    : 32'd0;
    issue_inst1_pc_o    = issue_inst1_valid_o ? pc_mem[head]      : 32'd0;
    issue_inst2_o       = issue_inst2_valid_o ? inst_mem[head_p1] : 32'd0;
    issue_inst2_pc_o    = issue_inst2_valid_o ? pc_mem[head_p1]   : 32'd0;
    count_o             = count;
    full_o              = free < CW'(FULL_MARGIN);
    empty_o             = (count == '0);
    overflow_o          = overflow_q;
  end

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed scenarios with literal
// expectations plus randomized traffic checked against a queue model.
module tb_inst_queue;

  localparam int DEPTH       = 16;
  localparam int FULL_MARGIN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush, stall;
  logic [31:0] wr_inst1, wr_inst1_pc, wr_inst2, wr_inst2_pc;
  logic        wr_inst1_valid, wr_inst2_valid;
  logic        issue, issue_mode;
  logic [31:0] issue_inst1, issue_inst1_pc, issue_inst2, issue_inst2_pc;
  logic        issue_inst1_valid, issue_inst2_valid;
  logic [4:0]  count;
  logic        full, empty, overflow;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH), .FULL_MARGIN(FULL_MARGIN)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .stall               (stall),
    .wr_inst1_i          (wr_inst1),
    .wr_inst1_pc_i       (wr_inst1_pc),
    .wr_inst1_valid_i    (wr_inst1_valid),
    .wr_inst2_i          (wr_inst2),
    .wr_inst2_pc_i       (wr_inst2_pc),
    .wr_inst2_valid_i    (wr_inst2_valid),
    .issue_i             (issue),
    .issue_mode_i        (issue_mode),
    .issue_inst1_o       (issue_inst1),
    .issue_inst1_pc_o    (issue_inst1_pc),
    .issue_inst1_valid_o (issue_inst1_valid),
    .issue_inst2_o       (issue_inst2),
    .issue_inst2_pc_o    (issue_inst2_pc),
    .issue_inst2_valid_o (issue_inst2_valid),
    .count_o             (count),
    .full_o              (full),
    .empty_o             (empty),
    .overflow_o          (overflow)
  );

  // Reference model: program-ordered queue of {pc, inst} entries.
  logic [63:0] mq[$];
  logic [63:0] incoming[$];
  logic        m_ovf;
  int          m_free;
  int          m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      mq.delete();
      m_ovf = 1'b0;
    end else if (stall) begin
      m_ovf = 1'b0;
    end else begin
      incoming.delete();
      if (wr_inst1_valid) incoming.push_back({wr_inst1_pc, wr_inst1});
      if (wr_inst2_valid) incoming.push_back({wr_inst2_pc, wr_inst2});
      m_free = DEPTH - mq.size();
      m_ovf  = (incoming.size() > m_free);
      m_pop  = issue ? (issue_mode ? 2 : 1) : 0;
      if (m_pop > mq.size()) m_pop = mq.size();
      repeat (m_pop) void'(mq.pop_front());
      for (int i = 0; i < incoming.size() && i < m_free; i++)
        mq.push_back(incoming[i]);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Every cycle outside reset, all outputs are compared against the model.
  always @(negedge clk) begin : compare_proc
    int n;
    logic [63:0] e1, e2;
    if (!rst) begin
      n  = mq.size();
      e1 = (n >= 1) ? mq[0] : 64'd0;
      e2 = (n >= 2) ? mq[1] : 64'd0;
      checkOutput("model count",    32'(count),             32'(n));
      checkOutput("model empty",    32'(empty),             32'(n == 0));
      checkOutput("model full",     32'(full),              32'((DEPTH - n) < FULL_MARGIN));
      checkOutput("model overflow", 32'(overflow),          32'(m_ovf));
      checkOutput("model v1",       32'(issue_inst1_valid), 32'(n >= 1));
      checkOutput("model v2",       32'(issue_inst2_valid), 32'(n >= 2));
      checkOutput("model inst1",    issue_inst1,            e1[31:0]);
      checkOutput("model pc1",      issue_inst1_pc,         e1[63:32]);
      checkOutput("model inst2",    issue_inst2,            e2[31:0]);
      checkOutput("model pc2",      issue_inst2_pc,         e2[63:32]);
    end
  end

  // Drives one cycle of inputs, returns at the following negedge with idle inputs.
  task automatic applyStimulus(input logic v1, input logic [31:0] pc1,
                               input logic v2, input logic [31:0] pc2,
                               input logic iss, input logic mode,
                               input logic fl, input logic st);
    wr_inst1_valid = v1;
    wr_inst1_pc    = pc1;
    wr_inst1       = $urandom;
    wr_inst2_valid = v2;
    wr_inst2_pc    = pc2;
    wr_inst2       = $urandom;
    issue          = iss;
    issue_mode     = mode;
    flush          = fl;
    stall          = st;
    @(negedge clk);
    wr_inst1_valid = 1'b0;
    wr_inst2_valid = 1'b0;
    issue          = 1'b0;
    issue_mode     = 1'b0;
    flush          = 1'b0;
    stall          = 1'b0;
  endtask

  task automatic writeDual(input logic [31:0] pc);
    applyStimulus(1'b1, pc, 1'b1, pc + 32'd4, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic writeSingle(input logic [31:0] pc);
    applyStimulus(1'b1, pc, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic popN(input logic mode);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, mode, 1'b0, 1'b0);
  endtask

  task automatic doFlush();
    applyStimulus(1'b1, 32'hDEAD0000, 1'b1, 32'hDEAD0004, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    flush = 0; stall = 0; issue = 0; issue_mode = 0;
    wr_inst1 = 0; wr_inst1_pc = 0; wr_inst1_valid = 0;
    wr_inst2 = 0; wr_inst2_pc = 0; wr_inst2_valid = 0;

    #2 rst = 1'b1;
    #10 rst = 1'b0;
    @(negedge clk);
    checkOutput("reset count", 32'(count), 32'd0);
    checkOutput("reset empty", 32'(empty), 32'd1);
    checkOutput("reset full",  32'(full),  32'd0);
    checkOutput("reset v1",    32'(issue_inst1_valid), 32'd0);
    checkOutput("reset pc1",   issue_inst1_pc, 32'd0);

    for (int i = 0; i < 8; i++) writeDual(32'hBFC00000 + 32'(8 * i));
    checkOutput("fill count", 32'(count), 32'd16);
    checkOutput("fill full",  32'(full),  32'd1);
    checkOutput("fill pc1",   issue_inst1_pc, 32'hBFC00000);
    checkOutput("fill pc2",   issue_inst2_pc, 32'hBFC00004);

    doFlush();
    checkOutput("flush count", 32'(count), 32'd0);
    checkOutput("flush v1",    32'(issue_inst1_valid), 32'd0);
    checkOutput("flush v2",    32'(issue_inst2_valid), 32'd0);

    for (int i = 0; i < 6; i++) writeDual(32'h5000 + 32'(8 * i));
    checkOutput("margin 12 full", 32'(full), 32'd0);
    writeSingle(32'h5030);
    checkOutput("margin 13 count", 32'(count), 32'd13);
    checkOutput("margin 13 full",  32'(full),  32'd1);

    applyStimulus(1'b1, 32'h9000, 1'b1, 32'h9004, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("stall count", 32'(count), 32'd13);
    checkOutput("stall pc1",   issue_inst1_pc, 32'h5000);
    writeSingle(32'h5034);
    popN(1'b0);
    checkOutput("stall tail pc", 32'(count), 32'd13);
    checkOutput("stall head pc", issue_inst1_pc, 32'h5004);

    doFlush();
    writeDual(32'h6000);
    writeDual(32'h6008);
    writeSingle(32'h6010);
    popN(1'b1);
    checkOutput("mixed count 3", 32'(count), 32'd3);
    checkOutput("mixed pc1 a",   issue_inst1_pc, 32'h6008);
    popN(1'b0);
    checkOutput("mixed count 2", 32'(count), 32'd2);
    checkOutput("mixed pc1 b",   issue_inst1_pc, 32'h600C);
    popN(1'b1);
    checkOutput("mixed count 0", 32'(count), 32'd0);
    writeSingle(32'h7000);
    checkOutput("one entry v2", 32'(issue_inst2_valid), 32'd0);
    popN(1'b1);
    checkOutput("underflow count", 32'(count), 32'd0);
    popN(1'b1);
    checkOutput("empty pop count", 32'(count), 32'd0);
    checkOutput("empty pop empty", 32'(empty), 32'd1);

    applyStimulus(1'b0, 32'd0, 1'b1, 32'h1004, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("compact pc1",   issue_inst1_pc, 32'h1004);
    checkOutput("compact v1",    32'(issue_inst1_valid), 32'd1);
    checkOutput("compact v2",    32'(issue_inst2_valid), 32'd0);
    checkOutput("compact count", 32'(count), 32'd1);

    doFlush();
    for (int i = 0; i < 7; i++) writeDual(32'h2000 + 32'(8 * i));
    writeSingle(32'h2038);
    writeDual(32'h3000);
    checkOutput("wrap count",    32'(count),    32'd16);
    checkOutput("wrap overflow", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("overflow pulse", 32'(overflow), 32'd0);
    for (int i = 0; i < 7; i++) popN(1'b1);
    popN(1'b0);
    checkOutput("wrap idx15 pc", issue_inst1_pc, 32'h3000);
    applyStimulus(1'b1, 32'h4000, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("wrap idx0 pc",  issue_inst1_pc, 32'h4000);
    checkOutput("wrap idx0 cnt", 32'(count), 32'd1);

    for (int c = 0; c < 3000; c++) begin
      applyStimulus($urandom_range(3) != 0, $urandom,
                    $urandom_range(3) != 0, $urandom,
                    $urandom_range(1) != 0, $urandom_range(1) != 0,
                    $urandom_range(31) == 0, $urandom_range(7) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
